// File: rtl/cond_sub_serial_if.sv
// Handshake and operand bus for the chunk-serial conditional subtractor.
// The master issues start/a/b. The slave returns busy/done/r/ge.
interface cond_sub_serial_if #(
    parameter int N = 1024
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] r;
    logic         ge;

    modport master (output start, a, b, input busy, done, r, ge);
    modport slave  (input start, a, b, output busy, done, r, ge);
endinterface

// File: rtl/cond_sub_serial.sv
// Conditional subtractor r = (a >= b) ? a - b : a, evaluated W bits per cycle.
// The only state carried from one chunk to the next is the carry of a + ~b + 1.
module cond_sub_serial #(
    parameter int N = 1024,
    parameter int W = 64
) (
    input  logic               clk,
    input  logic               rst,
    cond_sub_serial_if.slave   bus
);
    localparam int NCH = N / W;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, SEL} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, b_q, diff_q, r_q;
    logic [KW-1:0] k_q;
    logic          carry_q, ge_q, busy_q, done_q;

    logic          capture_en, run_en, sel_en, busy_d, done_d;
    logic [W:0]    sum;

    // One W-bit slice of a + ~b + carry; its top bit is the carry into the next chunk.
    always_comb begin
        sum = {1'b0, a_q[k_q*W +: W]} + {1'b0, ~b_q[k_q*W +: W]} + {{W{1'b0}}, carry_q};
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start)       state_d = RUN;
            RUN:  if (k_q == K_LAST)   state_d = SEL;
            SEL:                       state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        capture_en = (state_q == IDLE) && bus.start;
        run_en     = (state_q == RUN);
        sel_en     = (state_q == SEL);
        busy_d     = (state_d != IDLE);
        done_d     = sel_en;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide operand and difference registers are cleared as well, so no stale operand survives a reset.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            r_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            ge_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (capture_en) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                k_q     <= '0;
                carry_q <= 1'b1;
            end
            if (run_en) begin
                diff_q[k_q*W +: W] <= sum[W-1:0];
                carry_q            <= sum[W];
                k_q                <= k_q + 1'b1;
            end
            if (sel_en) begin
                ge_q <= carry_q;
                r_q  <= carry_q ? diff_q : a_q;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r    = r_q;
    assign bus.ge   = ge_q;
endmodule

// File: tb/tb_cond_sub_serial.sv
// Testbench for cond_sub_serial: a table of directed vectors, hand-written reset
// and ignored-start sequences, and random operands checked against an arithmetic model.
module tb_cond_sub_serial;
    localparam int N   = 1024;
    localparam int W   = 64;
    localparam int NCH = N / W;

    typedef logic [N-1:0] word_t;

    typedef struct {
        string name;
        word_t a;
        word_t b;
        word_t exp_r;
        logic  exp_ge;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    word_t prev_r;

    cond_sub_serial_if #(.N(N)) bus ();

    cond_sub_serial #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t got, input word_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got low128=%h required low128=%h", name, got[127:0], exp[127:0]);
        end
    endtask

    function automatic void model(input word_t a, input word_t b, output word_t r, output logic ge);
        ge = (a >= b);
        r  = ge ? a - b : a;
    endfunction

    function automatic word_t rand_wide();
        word_t v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Issues one operation at the current negedge. Operand inputs are scrambled after
    // acceptance, and an optional second start is poked at cycle poke_at of the run.
    task automatic do_op(input word_t ta, input word_t tb_v, input int poke_at,
                         output word_t r_mid, output word_t got_r, output logic got_ge,
                         output int lat, output int busy_cnt, output bit ok);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(posedge clk);
        lat = -1; busy_cnt = 0; ok = 1'b0; r_mid = '0; got_r = '0; got_ge = 1'b0;
        for (int idx = 0; idx < 4 * NCH + 8; idx++) begin
            @(negedge clk);
            if (idx == 3) r_mid = bus.r;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                got_r = bus.r; got_ge = bus.ge; lat = idx; ok = 1'b1;
                break;
            end
            bus.start = (idx == poke_at);
            bus.a     = ~ta;
            bus.b     = ta;
        end
        bus.start = 1'b0;
    endtask

    task automatic run_check(input string name, input word_t ta, input word_t tb_v,
                             input word_t exp_r, input logic exp_ge, input int poke_at);
        word_t r_mid, got_r;
        logic  got_ge;
        int    lat, busy_cnt;
        bit    ok;
        do_op(ta, tb_v, poke_at, r_mid, got_r, got_ge, lat, busy_cnt, ok);
        check({name, " done seen"}, word_t'(ok), word_t'(1));
        check({name, " latency"}, word_t'(lat), word_t'(NCH + 1));
        check({name, " busy cycles"}, word_t'(busy_cnt), word_t'(NCH + 1));
        check({name, " r held"}, r_mid, prev_r);
        check({name, " r"}, got_r, exp_r);
        check({name, " ge"}, word_t'(got_ge), word_t'(exp_ge));
        prev_r = exp_r;
    endtask

    vec_t  vecs[$];
    word_t one_hi64, one_hi960, mr;
    logic  mge;
    int    extra_done;

    initial begin
        one_hi64  = '0; one_hi64[64]   = 1'b1;
        one_hi960 = '0; one_hi960[960] = 1'b1;
        vecs.push_back('{"5-3",      word_t'(5),  word_t'(3), word_t'(2), 1'b1});
        vecs.push_back('{"3-5",      word_t'(3),  word_t'(5), word_t'(3), 1'b0});
        vecs.push_back('{"max-max",  '1,          '1,         '0,         1'b1});
        vecs.push_back('{"2^64-1",   one_hi64,    word_t'(1), one_hi64 - word_t'(1), 1'b1});
        vecs.push_back('{"2^960-1",  one_hi960,   word_t'(1), one_hi960 - word_t'(1), 1'b1});
        vecs.push_back('{"0-0",      '0,          '0,         '0,         1'b1});
        vecs.push_back('{"0-1",      '0,          word_t'(1), '0,         1'b0});
        vecs.push_back('{"1-2^960",  word_t'(1),  one_hi960,  word_t'(1), 1'b0});

        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        prev_r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", word_t'(bus.busy), '0);
        check("reset done", word_t'(bus.done), '0);
        check("reset r",    bus.r,             '0);
        check("reset ge",   word_t'(bus.ge),   '0);

        // Consecutive calls issue the next start in the done cycle (back-to-back).
        foreach (vecs[i])
            run_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_ge, -1);

        // A start during RUN chunk 5 is ignored and must not spawn a second done.
        run_check("poke", word_t'(100), word_t'(7), word_t'(93), 1'b1, 5);
        extra_done = 0;
        for (int i = 0; i < NCH + 4; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra_done++;
        end
        check("no second op", word_t'(extra_done), '0);

        // Reset for one cycle at RUN chunk 8, with start also high.
        bus.start = 1'b1; bus.a = word_t'(77); bus.b = word_t'(1);
        @(posedge clk);
        for (int idx = 0; idx <= 8; idx++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("midrun rst busy", word_t'(bus.busy), '0);
        check("midrun rst done", word_t'(bus.done), '0);
        check("midrun rst r",    bus.r,             '0);
        check("midrun rst ge",   word_t'(bus.ge),   '0);
        @(negedge clk);
        check("rst beats start", word_t'(bus.busy), '0);
        prev_r = '0;
        run_check("10-4", word_t'(10), word_t'(4), word_t'(6), 1'b1, -1);

        for (int n = 0; n < 24; n++) begin
            word_t ra, rb;
            ra = rand_wide();
            rb = rand_wide();
            case ($urandom_range(0, 3))
                1: rb = ra;
                2: ra = rb + word_t'($urandom_range(0, 3));
                3: rb = ra + word_t'(1);
                default: ;
            endcase
            model(ra, rb, mr, mge);
            run_check($sformatf("rand%0d", n), ra, rb, mr, mge, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
